timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 104 ++++++++++
 tb/tb_timer_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counter with one-shot / auto-reload
// modes and a maskable interrupt request. Reads are zero-latency.
module timer_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] ctrl;
   logic [DW-1:0] preset;
   logic [DW-1:0] count;
   logic          intflag;

   logic enable;
   logic reload;
   logic mask;
   logic wr_ctrl;
   logic wr_preset;

   assign enable    = ctrl[0];
   assign reload    = (ctrl[2:1] == 2'd1);
   assign mask      = ctrl[3];
   assign wr_ctrl   = we && (addr == ADDR_CTRL);
   assign wr_preset = we && (addr == ADDR_PRESET);

   // Register file updates and counter FSM; a CPU write to CTRL overrides the
   // hardware clear of Enable, while an expiry sets intflag over a CPU clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ctrl    <= '0;
         preset  <= '0;
         count   <= '0;
         intflag <= 1'b0;
      end else begin
         if (wr_preset) preset <= din;
         if (wr_ctrl)   ctrl   <= din[CW-1:0];
         if (wr_ctrl || wr_preset) intflag <= 1'b0;

         case (state)
            IDLE: begin
               if (enable) state <= LOAD;
            end
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (count > DW'(1)) begin
                  count <= count - DW'(1);
               end else begin
                  count   <= '0;
                  intflag <= 1'b1;
                  state   <= INT;
               end
            end
            INT: begin
               state <= IDLE;
               if (reload) begin
                  intflag <= 1'b0;
               end else if (!wr_ctrl) begin
                  ctrl[0] <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Zero-latency register read mux.
   always_comb begin
      dout = '0;
      case (addr)
         ADDR_CTRL:   dout = {(DW-CW)'(0), ctrl};
         ADDR_PRESET: dout = preset;
         ADDR_COUNT:  dout = count;
         default:     dout = '0;
      endcase
   end

   assign irq = intflag & mask;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed scenarios followed by random
// bus traffic, checked every cycle against a deadline-based reference model.
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  addr = 2'd0;
   logic        we = 1'b0;
   logic [31:0] din = 32'd0;
   logic [31:0] dout;
   logic        irq;

   timer_counter dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic [31:0] dout;
      logic        irq;
      logic [1:0]  addr;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: a run is "armed" one edge after Enable is seen while
   // idle, "started" at the load edge, and expires max(P,1) edges later.
   localparam int PH_IDLE = 0;
   localparam int PH_ARMED = 1;
   localparam int PH_RUN = 2;
   localparam int PH_EXPIRED = 3;

   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   logic [31:0] m_load;
   logic        m_flag;
   int          m_phase;
   int          m_cyc;
   int          m_start;

   function automatic void model_reset();
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_load = 32'd0;
      m_flag = 1'b0; m_phase = PH_IDLE; m_cyc = 0; m_start = 0;
   endfunction

   function automatic void model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
      logic [3:0]  nctrl;
      logic [31:0] npreset, ncount, k, span;
      logic        nflag, en, auto_reload, ctrl_wr;
      int          nphase;
      nctrl = m_ctrl; npreset = m_preset; ncount = m_count; nflag = m_flag; nphase = m_phase;
      en = m_ctrl[0];
      auto_reload = (m_ctrl[2:1] == 2'd1);
      ctrl_wr = w && (a == 2'd0);
      if (ctrl_wr) begin nctrl = d[3:0]; nflag = 1'b0; end
      if (w && a == 2'd1) begin npreset = d; nflag = 1'b0; end
      case (m_phase)
         PH_IDLE: if (en) nphase = PH_ARMED;
         PH_ARMED: begin
            m_start = m_cyc; m_load = m_preset; ncount = m_preset; nphase = PH_RUN;
         end
         PH_RUN: begin
            if (!en) begin
               nphase = PH_IDLE;
            end else begin
               k = 32'(m_cyc - m_start);
               span = (m_load == 32'd0) ? 32'd1 : m_load;
               if (k >= span) begin
                  ncount = 32'd0; nflag = 1'b1; nphase = PH_EXPIRED;
               end else begin
                  ncount = m_load - k;
               end
            end
         end
         default: begin
            nphase = PH_IDLE;
            if (auto_reload) nflag = 1'b0;
            else if (!ctrl_wr) nctrl[0] = 1'b0;
         end
      endcase
      m_ctrl = nctrl; m_preset = npreset; m_count = ncount; m_flag = nflag; m_phase = nphase;
      m_cyc++;
   endfunction

   function automatic exp_t expect_now(input logic [1:0] a);
      exp_t e;
      e.addr = a;
      e.irq = m_flag & m_ctrl[3];
      case (a)
         2'd0: e.dout = {28'd0, m_ctrl};
         2'd1: e.dout = m_preset;
         2'd2: e.dout = m_count;
         default: e.dout = 32'd0;
      endcase
      return e;
   endfunction

   // One bus cycle: advance the model over the edge, then drive the next access.
   task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
      @(posedge clk);
      if (!reset) model_edge(we, addr, din);
      #1;
      we = w; addr = a; din = d;
      sb.push_back(expect_now(a));
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once.
   task automatic reset_pulse();
      @(posedge clk);
      if (!reset) model_edge(we, addr, din);
      #1;
      reset = 1'b1; we = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         addr = 2'(i);
         #1;
         n_cmp++;
         if (dout !== 32'd0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset addr=%0d got dout=%h irq=%b want dout=00000000 irq=0", i, dout, irq);
         end
      end
      sb.push_back(expect_now(addr));
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.push_back(expect_now(addr));
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (dout !== e.dout || irq !== e.irq) begin
               n_bad++;
               $display("FAIL read t=%0t addr=%0d got dout=%h irq=%b want dout=%h irq=%b",
                        $time, e.addr, dout, irq, e.dout, e.irq);
            end
         end
      end
   end

   initial begin
      int r;
      model_reset();
      @(posedge clk);
      #1;
      sb.push_back(expect_now(addr));
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.push_back(expect_now(addr));

      // One-shot, IM set: count down, sticky irq, CTRL write clears it.
      step(1'b1, 2'd1, 32'd3);
      step(1'b1, 2'd0, 32'h9);
      repeat (7) step(1'b0, 2'd2, 32'd0);
      step(1'b0, 2'd0, 32'd0);
      step(1'b0, 2'd0, 32'd0);
      step(1'b1, 2'd0, 32'h8);
      repeat (3) step(1'b0, 2'd0, 32'd0);

      // Auto-reload: periodic one-cycle irq pulses.
      step(1'b1, 2'd1, 32'd2);
      step(1'b1, 2'd0, 32'hB);
      repeat (16) step(1'b0, 2'd2, 32'd0);

      // Reset in the middle of an auto-reload count.
      step(1'b1, 2'd1, 32'd5);
      repeat (6) step(1'b0, 2'd2, 32'd0);
      reset_pulse();
      repeat (4) step(1'b0, 2'd2, 32'd0);

      // Masked one-shot, then unmasking after a CTRL write.
      step(1'b1, 2'd1, 32'd4);
      step(1'b1, 2'd0, 32'h1);
      repeat (10) step(1'b0, 2'd0, 32'd0);
      step(1'b1, 2'd0, 32'h8);
      repeat (3) step(1'b0, 2'd0, 32'd0);

      // Disable mid-count freezes COUNT; PRESET=0 expires quickly.
      step(1'b1, 2'd1, 32'd20);
      step(1'b1, 2'd0, 32'h1);
      repeat (14) step(1'b0, 2'd2, 32'd0);
      step(1'b1, 2'd0, 32'h0);
      repeat (4) step(1'b0, 2'd2, 32'd0);
      step(1'b1, 2'd1, 32'd0);
      step(1'b1, 2'd0, 32'h1);
      repeat (6) step(1'b0, 2'd2, 32'd0);

      // Read-only and unused offsets; CTRL keeps only four bits.
      step(1'b1, 2'd2, 32'hFFFF_FFFF);
      step(1'b0, 2'd2, 32'd0);
      step(1'b1, 2'd3, 32'hFFFF_FFFF);
      step(1'b0, 2'd3, 32'd0);
      step(1'b1, 2'd0, 32'hFFFF_FFFF);
      step(1'b0, 2'd0, 32'd0);
      step(1'b1, 2'd0, 32'h0);

      // Random bus traffic.
      for (int i = 0; i < 4000; i++) begin
         r = 32'($urandom_range(0, 999));
         if (r < 2) reset_pulse();
         else if (r < 40) step(1'b1, 2'd0, $urandom);
         else if (r < 110) step(1'b1, 2'd1, 32'($urandom_range(0, 7)));
         else if (r < 113) step(1'b1, 2'd1, $urandom);
         else if (r < 140) step(1'b1, 2'($urandom_range(2, 3)), $urandom);
         else step(1'b0, 2'($urandom_range(0, 3)), $urandom);
      end

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain pending=%0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
